// File: rtl/ina219_poll_ctrl.sv
// ina219_poll_ctrl: autonomous INA219 poller driving an i2c_master.
// Each round reads shunt-voltage (0x01), bus-voltage (0x02), power (0x03)
// and current (0x04). Every read is a pointer write followed by a read.
// The four results are committed together with a one-cycle sample_valid.
// Optional feature macro: INA_POLL_CONFIG_EN. When it is defined, the first
// round after reset is preceded by one write of CFG_VALUE to register 0x00.
module ina219_poll_ctrl #(
  parameter logic [6:0]  SLV_ADDR    = 7'h40,
  parameter int unsigned POLL_DIV    = 100000,
  parameter int unsigned GAP_CYC     = 5,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [15:0] CFG_VALUE   = 16'h399F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        m_start,
  output logic        m_rd_wr,
  output logic [6:0]  m_slv_addr,
  output logic [7:0]  m_pointer,
  output logic [15:0] m_tx_data,
  input  logic [15:0] m_rx_data,
  input  logic        m_eot,
  output logic [15:0] shunt_v,
  output logic [15:0] bus_v,
  output logic [15:0] power,
  output logic [15:0] current,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned PW = $clog2(POLL_DIV);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);

`ifdef INA_POLL_CONFIG_EN
  typedef enum logic [3:0] {
    IDLE, CFG_START, CFG_WAIT, WAIT_TICK, PTR_START, PTR_WAIT,
    GAP, RD_START, RD_WAIT, STORE, COMMIT
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, WAIT_TICK, PTR_START, PTR_WAIT,
    GAP, RD_START, RD_WAIT, STORE, COMMIT
  } state_t;
`endif

  state_t        state;
  logic [1:0]    idx;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wait_cnt;
  logic [PW-1:0] poll_cnt;
  logic          eot_q;
  logic          eot_edge;
  logic [15:0]   shadow [4];

`ifdef INA_POLL_CONFIG_EN
  logic          cfg_pending;
  logic [15:0]   tx_data_r;
  assign m_tx_data = tx_data_r;
`else
  logic          unused_cfg;
  assign unused_cfg = ^CFG_VALUE;
  assign m_tx_data  = '0;
`endif

  assign m_slv_addr = SLV_ADDR;
  assign eot_edge   = m_eot & ~eot_q;
  assign busy       = (state != IDLE) && (state != WAIT_TICK);

  function automatic logic [7:0] ptr_of(input logic [1:0] i);
    return {6'd0, i} + 8'd1;
  endfunction

  // Sequencer: start cycles are entered with m_start and the command
  // fields set together, so m_start is high exactly for the start state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      gap_cnt      <= '0;
      wait_cnt     <= '0;
      poll_cnt     <= '0;
      eot_q        <= 1'b0;
      m_start      <= 1'b0;
      m_rd_wr      <= 1'b0;
      m_pointer    <= '0;
      shunt_v      <= '0;
      bus_v        <= '0;
      power        <= '0;
      current      <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
`ifdef INA_POLL_CONFIG_EN
      cfg_pending  <= 1'b1;
      tx_data_r    <= '0;
`endif
    end else begin
      eot_q        <= m_eot;
      m_start      <= 1'b0;
      sample_valid <= 1'b0;
      if (poll_cnt != '0) poll_cnt <= poll_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
`ifdef INA_POLL_CONFIG_EN
            if (cfg_pending) begin
              state     <= CFG_START;
              m_start   <= 1'b1;
              m_rd_wr   <= 1'b0;
              m_pointer <= 8'h00;
              tx_data_r <= CFG_VALUE;
            end else begin
              state     <= PTR_START;
              idx       <= '0;
              poll_cnt  <= POLL_LOAD;
              m_start   <= 1'b1;
              m_rd_wr   <= 1'b0;
              m_pointer <= ptr_of(2'd0);
            end
`else
            state     <= PTR_START;
            idx       <= '0;
            poll_cnt  <= POLL_LOAD;
            m_start   <= 1'b1;
            m_rd_wr   <= 1'b0;
            m_pointer <= ptr_of(2'd0);
`endif
          end
        end

`ifdef INA_POLL_CONFIG_EN
        CFG_START: begin
          cfg_pending <= 1'b0;
          wait_cnt    <= '0;
          state       <= CFG_WAIT;
        end

        // A config timeout is flagged but polling still starts.
        CFG_WAIT: begin
          if (eot_edge || wait_cnt == TO_LIMIT) begin
            if (!eot_edge) timeout_err <= 1'b1;
            state     <= PTR_START;
            idx       <= '0;
            poll_cnt  <= POLL_LOAD;
            m_start   <= 1'b1;
            m_rd_wr   <= 1'b0;
            m_pointer <= ptr_of(2'd0);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
`endif

        WAIT_TICK: begin
          if (poll_cnt == '0) begin
            if (enable) begin
              state     <= PTR_START;
              idx       <= '0;
              poll_cnt  <= POLL_LOAD;
              m_start   <= 1'b1;
              m_rd_wr   <= 1'b0;
              m_pointer <= ptr_of(2'd0);
            end else begin
              state <= IDLE;
            end
          end
        end

        PTR_START: begin
          wait_cnt <= '0;
          state    <= PTR_WAIT;
        end

        PTR_WAIT: begin
          if (eot_edge) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else if (wait_cnt == TO_LIMIT) begin
            timeout_err <= 1'b1;
            state       <= WAIT_TICK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= RD_START;
            m_start <= 1'b1;
            m_rd_wr <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        RD_START: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end

        RD_WAIT: begin
          if (eot_edge) begin
            state <= STORE;
          end else if (wait_cnt == TO_LIMIT) begin
            timeout_err <= 1'b1;
            state       <= WAIT_TICK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        STORE: begin
          shadow[idx] <= m_rx_data;
          if (idx == 2'd3) begin
            state <= COMMIT;
          end else begin
            idx       <= idx + 2'd1;
            state     <= PTR_START;
            m_start   <= 1'b1;
            m_rd_wr   <= 1'b0;
            m_pointer <= ptr_of(idx + 2'd1);
          end
        end

        COMMIT: begin
          shunt_v      <= shadow[0];
          bus_v        <= shadow[1];
          power        <= shadow[2];
          current      <= shadow[3];
          sample_valid <= 1'b1;
          state        <= WAIT_TICK;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ina219_poll_ctrl.sv
// Bench for ina219_poll_ctrl: a slave model answers every master command,
// expected commands and committed samples are queued by the stimulus and
// checked by an independent monitor on the falling clock edge.
module tb_ina219_poll_ctrl;

  localparam int unsigned GAP   = 5;
  localparam int unsigned TMO   = 100;
  localparam int unsigned PDIV  = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        m_start;
  logic        m_rd_wr;
  logic [6:0]  m_slv_addr;
  logic [7:0]  m_pointer;
  logic [15:0] m_tx_data;
  logic [15:0] m_rx_data;
  logic        m_eot;
  logic [15:0] shunt_v, bus_v, power, current;
  logic        sample_valid;
  logic        busy;
  logic        timeout_err;

  ina219_poll_ctrl #(
    .SLV_ADDR    (7'h40),
    .POLL_DIV    (PDIV),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO),
    .CFG_VALUE   (16'h399F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .m_start      (m_start),
    .m_rd_wr      (m_rd_wr),
    .m_slv_addr   (m_slv_addr),
    .m_pointer    (m_pointer),
    .m_tx_data    (m_tx_data),
    .m_rx_data    (m_rx_data),
    .m_eot        (m_eot),
    .shunt_v      (shunt_v),
    .bus_v        (bus_v),
    .power        (power),
    .current      (current),
    .sample_valid (sample_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [7:0]  ptr;
    logic [15:0] tx;
    logic        tx_chk;
  } txn_t;

  txn_t        exp_txn [$];
  logic [63:0] exp_smp [$];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        drop_bus = 1'b0;
  logic [15:0] val_mask = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] reg_val(input logic [7:0] p);
    case (p)
      8'h01:   return 16'h0FA0;
      8'h02:   return 16'h1F40;
      8'h03:   return 16'h0320;
      8'h04:   return 16'h0640;
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic push_txn(input logic rw, input logic [7:0] ptr);
    txn_t t;
    t.rw = rw; t.ptr = ptr; t.tx = '0;
`ifdef INA_POLL_CONFIG_EN
    t.tx_chk = 1'b0;
`else
    t.tx_chk = 1'b1;
`endif
    exp_txn.push_back(t);
  endtask

  task automatic push_cfg();
`ifdef INA_POLL_CONFIG_EN
    txn_t t;
    t.rw = 1'b0; t.ptr = 8'h00; t.tx = 16'h399F; t.tx_chk = 1'b1;
    exp_txn.push_back(t);
`endif
  endtask

  // nregs registers of a round; a sample is expected only for full rounds
  task automatic push_round(input int nregs, input logic [15:0] mask);
    for (int i = 1; i <= nregs; i++) begin
      push_txn(1'b0, 8'(i));
      push_txn(1'b1, 8'(i));
    end
    if (nregs == 4)
      exp_smp.push_back({16'h0FA0 ^ mask, 16'h1F40 ^ mask, 16'h0320 ^ mask, 16'h0640 ^ mask});
  endtask

  // cond 0: sample_valid, 1: timeout_err, 2: read start of bus-voltage
  function automatic logic cond_met(input int k);
    case (k)
      0:       return sample_valid;
      1:       return timeout_err;
      default: return m_start && m_rd_wr && m_pointer == 8'h02;
    endcase
  endfunction

  task automatic wait_cond(input int k, input int lim, input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cond_met(k) && n < lim);
    if (!cond_met(k)) check(name, 64'd0, 64'd1);
  endtask

  // Slave model: EOT three cycles after each start, read data with EOT.
  initial begin : slave
    logic       pend;
    int         lat;
    logic       s_rw;
    logic [7:0] s_ptr;
    pend = 1'b0; lat = 0; s_rw = 1'b0; s_ptr = '0;
    m_eot = 1'b0;
    m_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      m_eot = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (m_start) begin
        pend = 1'b1; lat = 3; s_rw = m_rd_wr; s_ptr = m_pointer;
      end else if (pend) begin
        if (lat > 1) begin
          lat--;
        end else begin
          pend = 1'b0;
          if (!(drop_bus && s_rw && s_ptr == 8'h02)) begin
            m_eot = 1'b1;
            if (s_rw) m_rx_data = reg_val(s_ptr) ^ val_mask;
          end
        end
      end
    end
  end

  // Monitor: compares every start and every commit against the queues.
  initial begin : monitor
    int          cyc, last_wr_eot, sv_cyc, stab_err;
    logic        prev_start, cur_rw, b2b_pending;
    logic [7:0]  cur_ptr;
    txn_t        e;
    logic [63:0] s;
    cyc = 0; last_wr_eot = 0; sv_cyc = 0; stab_err = 0;
    prev_start = 1'b0; cur_rw = 1'b0; cur_ptr = '0; b2b_pending = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        cur_rw = 1'b0; cur_ptr = '0; stab_err = 0;
        prev_start = 1'b0; b2b_pending = 1'b0;
      end else begin
        if (m_start) begin
          check("start_not_consecutive", {63'd0, prev_start}, 64'd0);
          check("cmd_held_stable", 64'(stab_err), 64'd0);
          if (exp_txn.size() == 0) begin
            check("unexpected_start", {55'd0, m_rd_wr, m_pointer}, 64'hFFF);
          end else begin
            e = exp_txn.pop_front();
            check("cmd_rw_ptr", {55'd0, m_rd_wr, m_pointer}, {55'd0, e.rw, e.ptr});
            if (e.tx_chk) check("cmd_tx_data", 64'(m_tx_data), 64'(e.tx));
          end
          if (m_rd_wr) check("read_gap_after_eot", 64'(cyc - last_wr_eot), 64'(GAP + 1));
          if (b2b_pending) begin
            check("next_round_no_idle", 64'(cyc - sv_cyc), 64'd1);
            b2b_pending = 1'b0;
          end
          cur_rw = m_rd_wr; cur_ptr = m_pointer; stab_err = 0;
        end else if (m_rd_wr !== cur_rw || m_pointer !== cur_ptr) begin
          stab_err++;
        end
        prev_start = m_start;
        if (m_eot && !cur_rw) last_wr_eot = cyc;
        if (sample_valid) begin
          if (exp_smp.size() == 0) begin
            check("unexpected_sample_valid", {shunt_v, bus_v, power, current}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            s = exp_smp.pop_front();
            check("sample_values", {shunt_v, bus_v, power, current}, s);
          end
          sv_cyc = cyc;
          b2b_pending = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_m_start"},     64'(m_start), 64'd0);
    check({tag, "_m_rd_wr"},     64'(m_rd_wr), 64'd0);
    check({tag, "_m_pointer"},   64'(m_pointer), 64'd0);
    check({tag, "_m_tx_data"},   64'(m_tx_data), 64'd0);
    check({tag, "_m_slv_addr"},  64'(m_slv_addr), 64'h40);
    check({tag, "_results"},     {shunt_v, bus_v, power, current}, 64'd0);
    check({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_busy"},        64'(busy), 64'd0);
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin : stim
    int n;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy_without_enable", 64'(busy), 64'd0);

    // Rounds 1 and 2: nominal data, back-to-back since POLL_DIV < round.
    push_cfg();
    push_round(4, 16'h0000);
    push_round(4, 16'h0000);
    enable = 1'b1;
    wait_cond(0, 400, "wait_round1", n);
    wait_cond(0, 400, "wait_round2", n);

    // Round 3: bus-voltage read never ends; round 4 must recover.
    drop_bus = 1'b1;
    val_mask = 16'h1111;
    push_round(2, 16'h1111);
    push_round(4, 16'h2222);
    wait_cond(2, 400, "wait_round3_bus_read", n);
    check("busy_mid_round", 64'(busy), 64'd1);
    wait_cond(1, 400, "wait_timeout_err", n);
    check("timeout_latency_in_range", 64'(n >= int'(TMO) && n <= int'(TMO) + 3), 64'd1);
    check("timeout_err_set", 64'(timeout_err), 64'd1);
    check("results_kept_after_timeout", {shunt_v, bus_v, power, current},
          64'h0FA0_1F40_0320_0640);
    drop_bus = 1'b0;
    val_mask = 16'h2222;
    wait_cond(0, 400, "wait_round4", n);
    check("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Round 5: enable drops during the second register read.
    val_mask = 16'h3333;
    push_round(4, 16'h3333);
    wait_cond(2, 400, "wait_round5_bus_read", n);
    enable = 1'b0;
    wait_cond(0, 400, "wait_round5_commit", n);
    repeat (100) @(posedge clk);
    #1;
    check("idle_after_disable_busy", 64'(busy), 64'd0);
    check("no_pending_cmds_after_disable", 64'(exp_txn.size()), 64'd0);

    // Reset pulse: state clears, config (if built) is issued again.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset2");
    reset = 1'b0;
    val_mask = 16'h0F0F;
    push_cfg();
    push_round(4, 16'h0F0F);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_cond(0, 400, "wait_round6", n);
    enable = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("final_busy", 64'(busy), 64'd0);
    check("final_cmd_queue_empty", 64'(exp_txn.size()), 64'd0);
    check("final_sample_queue_empty", 64'(exp_smp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ina219_poll_ctrl.md
# ina219_poll_ctrl

Sequencer sitting between the system and `i2c_master`, which autonomously polls the INA219 power monitor. Each poll round reads the shunt-voltage, bus-voltage, power and current registers. A register read is a pointer-write transaction followed by a read transaction. The four results are published atomically with a one-cycle valid strobe. The controller owns the master's command inputs; no other requester drives `i2c_master` while this block is instantiated.

## Interface
- `SLV_ADDR`, 7'h40: INA219 7-bit slave address.
- `POLL_DIV`, 100000: clk cycles between round starts (≥ 2).
- `GAP_CYC`, 5: idle cycles between the pointer-write EOT and the read start (≥ 1).
- `TIMEOUT_CYC`, 65535: maximum cycles to wait for an EOT.
- `CFG_VALUE`, 16'h399F: value written to config register 0x00 (see Configuration).

- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: polling enable.
- `m_start` out 1: start pulse to master.
- `m_rd_wr` out 1: 0 = write (pointer or pointer+data), 1 = read.
- `m_slv_addr` out 7: always SLV_ADDR.
- `m_pointer` out 8: register pointer.
- `m_tx_data` out 16: write data (config only).
- `m_rx_data` in 16: master read data.
- `m_eot` in 1: master end-of-transaction.
- `shunt_v`, `bus_v`, `power`, `current` out 16 each: last committed results.
- `sample_valid` out 1: one-cycle pulse on commit.
- `busy` out 1: high whenever the FSM is not IDLE or WAIT_TICK.
- `timeout_err` out 1: sticky; cleared only by reset.

## Operation
- FSM states: IDLE, CFG_START, CFG_WAIT, WAIT_TICK, PTR_START, PTR_WAIT, GAP, RD_START, RD_WAIT, STORE, COMMIT.
- IDLE → (CFG_START if config pending, else PTR_START with idx=0) when `enable`=1.
- Register index idx 0..3 maps to pointers 0x01, 0x02, 0x03, 0x04, which land in `shunt_v`, `bus_v`, `power` and `current` respectively.
- PTR_START: `m_start`=1 for one cycle, `m_rd_wr`=0, `m_pointer`=ptr(idx) → PTR_WAIT.
- PTR_WAIT: on EOT edge → GAP. GAP counts GAP_CYC cycles → RD_START.
- RD_START: `m_start`=1 for one cycle, `m_rd_wr`=1 → RD_WAIT.
- RD_WAIT: on EOT edge → STORE.
- STORE: latch `m_rx_data` into shadow[idx]. If idx<3, increment idx → PTR_START; else → COMMIT.
- COMMIT: copy all four shadows to the outputs and pulse `sample_valid` → WAIT_TICK.
- WAIT_TICK: wait for the poll tick, then go to PTR_START with idx=0 if `enable`=1, else to IDLE.
- EOT edge is defined as `m_eot`=1 while the registered previous `m_eot`=0. A level-high `m_eot` carried over from the previous transaction is ignored.
- Timeout: in any *_WAIT state, a wait counter reaching TIMEOUT_CYC sets `timeout_err`, discards the shadows (no commit, no `sample_valid`) and goes to WAIT_TICK.
- Deasserting `enable` mid-round does not abort the round; the round completes and commits, then the FSM returns to IDLE.

## Timing
- Reset values: all outputs 0, `m_slv_addr`=SLV_ADDR, FSM in IDLE, poll counter 0, config pending=1 (when enabled).
- `m_start` is never high for two consecutive cycles.
- `m_rd_wr`, `m_pointer` and `m_tx_data` are valid in the start cycle and held stable until the next start.
- Poll counter: loaded with POLL_DIV-1 on entering PTR_START with idx=0, decrements to 0 and saturates there. The tick is the counter being 0.
- If a round lasts longer than POLL_DIV, the next round starts in the cycle after COMMIT's WAIT_TICK entry.
- STORE lasts one cycle. COMMIT lasts one cycle. `sample_valid` is registered and coincides with the output update.
- Reset asserted mid-transaction returns to IDLE on the next edge. The master is reset by the same signal.

## Configuration
- `INA_POLL_CONFIG_EN` defined: after reset, the first round is preceded by one config write.
  - CFG_START: `m_start`, `m_rd_wr`=0, `m_pointer`=0x00, `m_tx_data`=CFG_VALUE.
  - CFG_WAIT: on EOT → PTR_START. On timeout, `timeout_err` is set and the FSM proceeds to PTR_START anyway.
  - The config write is issued once per reset.
- Undefined: CFG states are absent, and `m_tx_data` is tied to 0.

## Test plan
- Reset, then `enable`=1 with the slave model returning 0x0FA0, 0x1F40, 0x0320, 0x0640 → exactly one `sample_valid` per round, and `shunt_v`/`bus_v`/`power`/`current` equal those values.
- Check the pointer sequence on the bus → 0x01, 0x02, 0x03, 0x04, each write followed by a read ≥ GAP_CYC cycles after the write's EOT.
- Slave model never asserts EOT on the bus-voltage read → `timeout_err`=1 after TIMEOUT_CYC, outputs unchanged, no `sample_valid`, and the next round proceeds normally.
- `enable` dropped during the second register read → the round commits and the FSM idles with `busy`=0; no further `m_start`.
- With `INA_POLL_CONFIG_EN` defined → the first transaction is a write to 0x00 of 0x399F. No repeat on the second round; repeated after a reset pulse.
- POLL_DIV=50, shorter than a round → back-to-back rounds with no extra idle, and `m_start` never high for two consecutive cycles.
